segment_mem_wb: RTL and testbench

//  Memory stage plus MEM/WB pipeline register of the RSA pipeline CPU.
//  - Consumes EX/MEM outputs and drives the data-memory request.
//  - Waits on a variable-latency memory via a ready handshake and stalls upstream meanwhile.
//  - Registers the writeback bundle for the W stage.
//  - A wait-state watchdog drops a hung access and raises a sticky error.

---
 rtl/segment_mem_wb.sv | 144 ++++++++++++++
 tb/tb_segment_mem_wb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/segment_mem_wb.sv
// Memory stage and MEM/WB pipeline register.
// Issues the data-memory request and stalls upstream while a
// variable-latency access is outstanding. Writes back into the W
// register once the access completes, and inserts bubbles while it
// waits. A watchdog abandons a hung access and raises a sticky error.
// All state updates happen on the falling clock edge.
module segment_mem_wb #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic              FlagsWriteM,
    input  logic [REG_W-1:0]  WA3M,
    input  logic [3:0]        ALUFlagsM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              FlagsWriteW,
    output logic [REG_W-1:0]  WA3W,
    output logic [3:0]        ALUFlagsW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic              MemErr
);

    localparam int CNT_W = (TIMEOUT + 1 > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             memop;
    logic             load_wb;   // 1 = capture M bundle, 0 = insert bubble
    logic             set_err;

    assign memop     = MemtoRegM | MemWriteM;
    assign mem_addr  = ALUOutM;
    assign mem_wdata = WriteDataM;

    // Next-state, watchdog count and memory/stall outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_wb   = 1'b0;
        set_err   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        StallM    = 1'b0;
        case (state)
            IDLE: begin
                mem_req = memop;
                mem_we  = MemWriteM;
                StallM  = memop & ~mem_ready;
                if (memop && !mem_ready) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else begin
                    load_wb = 1'b1;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                mem_we  = MemWriteM;
                StallM  = ~mem_ready;
                if (mem_ready) begin
                    load_wb   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ERR;
                    set_err   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // Faulting instruction is dropped: no request, no stall, so
            // EX/MEM advances past it while a bubble goes to W.
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Outputs must be quiet during reset even though inputs may be live
        if (!reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            StallM  = 1'b0;
        end
    end

    // State register and wait counter
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // MEM/WB register: controls clear on a bubble, data fields hold
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            FlagsWriteW <= 1'b0;
            WA3W        <= '0;
            ALUFlagsW   <= '0;
            ALUOutW     <= '0;
            ReadDataW   <= '0;
        end else if (load_wb) begin
            RegWriteW   <= RegWriteM;
            MemtoRegW   <= MemtoRegM;
            FlagsWriteW <= FlagsWriteM;
            WA3W        <= WA3M;
            ALUFlagsW   <= ALUFlagsM;
            ALUOutW     <= ALUOutM;
            if (MemtoRegM) ReadDataW <= mem_rdata;
        end else begin
            RegWriteW   <= 1'b0;
            MemtoRegW   <= 1'b0;
            FlagsWriteW <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(negedge clk or negedge reset) begin
        if (!reset)       MemErr <= 1'b0;
        else if (set_err) MemErr <= 1'b1;
    end

endmodule

// File: tb/tb_segment_mem_wb.sv
// Bench for segment_mem_wb (TIMEOUT=4): a table of per-cycle vectors plus
// a reset-during-wait sequence. A shadow W register is updated from each
// vector's expected load/bubble outcome; the expected W bundle is queued
// at drive time and popped after the falling edge.
module tb_segment_mem_wb;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    logic              clk, reset;
    logic              RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM;
    logic [REG_W-1:0]  WA3M;
    logic [3:0]        ALUFlagsM;
    logic [DATA_W-1:0] ALUOutM, WriteDataM, mem_rdata;
    logic              mem_ready;
    logic              mem_req, mem_we, StallM;
    logic [DATA_W-1:0] mem_addr, mem_wdata;
    logic              RegWriteW, MemtoRegW, FlagsWriteW, MemErr;
    logic [REG_W-1:0]  WA3W;
    logic [3:0]        ALUFlagsW;
    logic [DATA_W-1:0] ALUOutW, ReadDataW;

    segment_mem_wb #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .FlagsWriteM(FlagsWriteM), .WA3M(WA3M), .ALUFlagsM(ALUFlagsM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .FlagsWriteW(FlagsWriteW), .WA3W(WA3W), .ALUFlagsW(ALUFlagsW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .MemErr(MemErr)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rw, m2r, mw, fw;
        logic [3:0]  wa3, flags;
        logic [31:0] alu, wd, rd;
        logic        rdy;
        logic        e_req, e_stall, e_load, e_err;
    } vec_t;

    typedef struct {
        logic        rw, m2r, fw;
        logic [3:0]  wa3, flags;
        logic [31:0] alu, rd;
        logic        err;
    } wb_t;

    vec_t vt[$];
    wb_t  shadow;
    wb_t  sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(string n, logic rw, logic m2r, logic mw, logic fw,
                                logic [3:0] wa3, logic [3:0] flags,
                                logic [31:0] alu, logic [31:0] wd, logic [31:0] rd,
                                logic rdy, logic e_req, logic e_stall,
                                logic e_load, logic e_err);
        vec_t v;
        v.name = n; v.rw = rw; v.m2r = m2r; v.mw = mw; v.fw = fw;
        v.wa3 = wa3; v.flags = flags; v.alu = alu; v.wd = wd; v.rd = rd;
        v.rdy = rdy; v.e_req = e_req; v.e_stall = e_stall;
        v.e_load = e_load; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        RegWriteM = v.rw; MemtoRegM = v.m2r; MemWriteM = v.mw; FlagsWriteM = v.fw;
        WA3M = v.wa3; ALUFlagsM = v.flags; ALUOutM = v.alu; WriteDataM = v.wd;
        mem_rdata = v.rd; mem_ready = v.rdy;
    endtask

    // Called just after a falling edge: drive, check combinational side,
    // queue the expected W bundle, cross the edge, compare W side.
    task automatic apply(input vec_t v);
        wb_t e;
        drive(v);
        #1;
        chk({v.name, ".mem_req"}, 32'(mem_req), 32'(v.e_req));
        chk({v.name, ".StallM"},  32'(StallM),  32'(v.e_stall));
        chk({v.name, ".mem_we"},  32'(mem_we),  32'(v.mw));
        chk({v.name, ".mem_addr"},  mem_addr,  v.alu);
        chk({v.name, ".mem_wdata"}, mem_wdata, v.wd);
        if (v.e_load) begin
            shadow.rw = v.rw; shadow.m2r = v.m2r; shadow.fw = v.fw;
            shadow.wa3 = v.wa3; shadow.flags = v.flags; shadow.alu = v.alu;
            if (v.m2r) shadow.rd = v.rd;
        end else begin
            shadow.rw = 1'b0; shadow.m2r = 1'b0; shadow.fw = 1'b0;
        end
        shadow.err = v.e_err;
        sb.push_back(shadow);
        @(negedge clk);
        #1;
        e = sb.pop_front();
        chk({v.name, ".RegWriteW"},   32'(RegWriteW),   32'(e.rw));
        chk({v.name, ".MemtoRegW"},   32'(MemtoRegW),   32'(e.m2r));
        chk({v.name, ".FlagsWriteW"}, 32'(FlagsWriteW), 32'(e.fw));
        chk({v.name, ".WA3W"},        32'(WA3W),        32'(e.wa3));
        chk({v.name, ".ALUFlagsW"},   32'(ALUFlagsW),   32'(e.flags));
        chk({v.name, ".ALUOutW"},     ALUOutW,          e.alu);
        chk({v.name, ".ReadDataW"},   ReadDataW,        e.rd);
        chk({v.name, ".MemErr"},      32'(MemErr),      32'(e.err));
    endtask

    task automatic chk_reset_state(input string n);
        chk({n, ".mem_req"},   32'(mem_req),   32'd0);
        chk({n, ".mem_we"},    32'(mem_we),    32'd0);
        chk({n, ".StallM"},    32'(StallM),    32'd0);
        chk({n, ".RegWriteW"}, 32'(RegWriteW), 32'd0);
        chk({n, ".MemtoRegW"}, 32'(MemtoRegW), 32'd0);
        chk({n, ".FlagsWriteW"}, 32'(FlagsWriteW), 32'd0);
        chk({n, ".WA3W"},      32'(WA3W),      32'd0);
        chk({n, ".ALUFlagsW"}, 32'(ALUFlagsW), 32'd0);
        chk({n, ".ALUOutW"},   ALUOutW,        32'd0);
        chk({n, ".ReadDataW"}, ReadDataW,      32'd0);
        chk({n, ".MemErr"},    32'(MemErr),    32'd0);
    endtask

    initial begin
        vec_t ld;
        //          name       rw m2r mw fw wa3 flg  alu          wd           rd           rdy req stl ld err
        vt.push_back(mk("alu3",    1,0,0,0, 3,  0, 32'h2A,      32'h0,       32'h0,       0, 0,0,1,0));
        vt.push_back(mk("alu_rdy", 1,0,0,1, 5, 10, 32'h77,      32'h0,       32'h5555,    1, 0,0,1,0));
        vt.push_back(mk("ld_0ws",  1,1,0,0, 7,  0, 32'h100,     32'h0,       32'hDEADBEEF,1, 1,0,1,0));
        vt.push_back(mk("st_w1",   0,0,1,0, 9,  3, 32'h200,     32'hCAFEF00D,32'hBAD0,    0, 1,1,0,0));
        vt.push_back(mk("st_w2",   0,0,1,0, 9,  3, 32'h200,     32'hCAFEF00D,32'hBAD0,    0, 1,1,0,0));
        vt.push_back(mk("st_w3",   0,0,1,0, 9,  3, 32'h200,     32'hCAFEF00D,32'hBAD0,    0, 1,1,0,0));
        vt.push_back(mk("st_done", 0,0,1,0, 9,  3, 32'h200,     32'hCAFEF00D,32'hBAD0,    1, 1,0,1,0));
        vt.push_back(mk("ldA_w",   1,1,0,0, 1,  0, 32'h300,     32'h0,       32'hBAD1,    0, 1,1,0,0));
        vt.push_back(mk("ldA_d",   1,1,0,0, 1,  0, 32'h300,     32'h0,       32'h11111111,1, 1,0,1,0));
        vt.push_back(mk("ldB_w",   1,1,0,0, 2,  0, 32'h304,     32'h0,       32'hBAD2,    0, 1,1,0,0));
        vt.push_back(mk("ldB_d",   1,1,0,0, 2,  0, 32'h304,     32'h0,       32'h22222222,1, 1,0,1,0));
        vt.push_back(mk("to_0",    1,1,0,0, 4,  0, 32'h400,     32'h0,       32'hBAD3,    0, 1,1,0,0));
        vt.push_back(mk("to_1",    1,1,0,0, 4,  0, 32'h400,     32'h0,       32'hBAD3,    0, 1,1,0,0));
        vt.push_back(mk("to_2",    1,1,0,0, 4,  0, 32'h400,     32'h0,       32'hBAD3,    0, 1,1,0,0));
        vt.push_back(mk("to_3",    1,1,0,0, 4,  0, 32'h400,     32'h0,       32'hBAD3,    0, 1,1,0,0));
        vt.push_back(mk("to_4",    1,1,0,0, 4,  0, 32'h400,     32'h0,       32'hBAD3,    0, 1,1,0,1));
        vt.push_back(mk("to_err",  1,1,0,0, 4,  0, 32'h400,     32'h0,       32'hBAD4,    1, 0,0,0,1));
        vt.push_back(mk("alu6",    1,0,0,0, 6,  0, 32'h55,      32'h0,       32'h0,       0, 0,0,1,1));

        shadow = '{default: '0};

        // Reset with a live load on the inputs: outputs must stay quiet
        reset = 1'b0;
        drive(mk("rst", 1,1,1,1, 15, 15, 32'h1234, 32'h5678, 32'h9ABC, 0, 0,0,0,0));
        #2;
        chk_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;

        foreach (vt[i]) apply(vt[i]);

        // Reset pulsed while a load is waiting
        ld = mk("rw_ld", 1,1,0,0, 12, 5, 32'h500, 32'h0, 32'hBAD5, 0, 1,1,0,1);
        apply(ld);
        drive(ld);
        #1;
        reset = 1'b0;
        #1;
        chk_reset_state("rst_wait");
        shadow = '{default: '0};
        @(negedge clk);
        #1;
        reset = 1'b1;
        apply(mk("post_alu", 1,0,0,1, 8, 6, 32'h99, 32'h0, 32'h0, 0, 0,0,1,0));
        // Full-length wait just short of the watchdog: counter restarted at 0
        for (int k = 0; k < 4; k++)
            apply(mk($sformatf("post_ld_w%0d", k), 1,1,0,0, 11, 0, 32'h600, 32'h0, 32'hBAD6, 0, 1,1,0,0));
        apply(mk("post_ld_d", 1,1,0,0, 11, 0, 32'h600, 32'h0, 32'h66666666, 1, 1,0,1,0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
